alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle sequencer in front of the combinational 32-bit ALU, which exposes ALU_Out, Zero and Overflow.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU select, operand, CarryIn and Sign inputs, one ALU pass per cycle.
- Composes 64-bit add (two passes with carry chaining) and N-bit shifts (N single-bit shift passes) from the ALU's primitive ops.
- Returns the result on a valid/ready response channel. Sits between the EX-stage control and the ALU instance.

Parameters:
- MAX_SHIFT, 31, shift counts above this clamp to MAX_SHIFT; legal range 1..31.
- CNT_W, 16, width of the optional op counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  0 ADD, 1 SUB, 2 ADDU, 3 SUBU, 4 ADD64, 5 SLL_N, 6 SRL_N, 7 SRA_N
- req_a  in  32  operand A; low word for ADD64
- req_b  in  32  operand B; low word for ADD64; shift count in bits [4:0] for ops 5-7
- req_a_hi  in  32  high word of A, ADD64 only
- req_b_hi  in  32  high word of B, ADD64 only
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  32  result, low word for ADD64
- rsp_data_hi  out  32  high word for ADD64, 0 otherwise
- rsp_ovf  out  1  overflow/carry flag
- rsp_zero  out  1  result is zero
- alu_sel  out  4  to ALU_Sel
- alu_a  out  32  to A
- alu_b  out  32  to B
- alu_carry_in  out  1  to CarryIn
- alu_sign  out  1  to Sign
- alu_out  in  32  from ALU_Out
- alu_zero  in  1  from Zero
- alu_overflow  in  1  from Overflow

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1; rsp_valid=0.
  - rsp_data, rsp_data_hi, rsp_ovf and rsp_zero are 0.
  - All alu_* outputs are 0. Any in-flight op is discarded.
- Outside EXEC, LO, HI and SHIFT, the alu_* outputs are 0.
- States:
  - IDLE: req_ready=1. On req_valid, latch all request fields and go to EXEC. req_ready is 0 in every other state.
  - EXEC (one cycle):
    - Ops 0-3: alu_sel=0 for ADD/ADDU, 1 for SUB/SUBU; alu_sign=1 for ADD/SUB, 0 for ADDU/SUBU; carry_in=0. Capture alu_out, alu_zero and alu_overflow, then go to RESP.
    - Op 4: go to LO.
    - Ops 5-7 with count=0: rsp_data=A, zero=(A==0), ovf=0, go to RESP.
    - Ops 5-7 with count>0: remaining=min(count,MAX_SHIFT), go to SHIFT.
  - LO: alu_sel=0, sign=0, carry_in=0, operands are the low words. Store the low result, lo_zero, and carry=alu_overflow. Go to HI.
  - HI: alu_sel=0, sign=0, carry_in=stored carry, operands are the high words.
    - rsp_data_hi=alu_out.
    - rsp_ovf=alu_overflow (carry out of A_hi+B_hi, excluding carry_in — this is the ALU detector's defined behaviour).
    - rsp_zero=lo_zero & alu_zero.
    - Go to RESP.
  - SHIFT:
    - alu_sel=4 (SLL), 5 (SRL) or 7 (SRA).
    - alu_a=working register, which is initialised to A at EXEC.
    - Each cycle: working<=alu_out; remaining decrements.
    - When remaining reaches 1 in this cycle: capture rsp_data and rsp_zero=alu_zero; rsp_ovf=0; go to RESP.
  - RESP: rsp_valid=1 and the outputs are held stable. When rsp_ready=1, go to IDLE in the next cycle. Back-to-back requests therefore have a 1-cycle IDLE gap.
- Latency from the request handshake cycle to rsp_valid:
  - 2 cycles for ops 0-3 and shift-by-0.
  - 4 cycles for ADD64.
  - 2+N cycles for shift-by-N.
- rsp_data_hi is 0 for every op except ADD64.
- Any req_op value is legal; there is no error case.

Optional Feature:
- Macro ALU_OP_SEQUENCER_CNT_EN.
- Defined: adds output op_count [CNT_W-1:0].
  - Reset value 0.
  - Increments by 1 on each response handshake (rsp_valid&rsp_ready).
  - Wraps from all-ones to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1 -> rsp_valid 2 cycles after accept; rsp_data=0x80000000, rsp_ovf=1, rsp_zero=0, rsp_data_hi=0.
- SUBU, A=5, B=5 -> rsp_data=0, rsp_zero=1; alu_sel observed =1 and alu_sign=0 during EXEC.
- ADD64, A=0x00000001_FFFFFFFF, B=0x00000000_00000001 -> alu_carry_in=1 in the HI pass; rsp_data=0, rsp_data_hi=2, rsp_zero=0, rsp_valid at 4 cycles.
- SRA_N, A=0x80000010, count 4 -> 4 SHIFT cycles with alu_sel=7; rsp_data=0xF8000001. SLL_N count 0 with A=0 -> rsp_data=0, rsp_zero=1, latency 2.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0. Assert rst_n=0 mid-SHIFT -> immediate IDLE, rsp_valid=0, alu_* outputs 0.
- With ALU_OP_SEQUENCER_CNT_EN and CNT_W=2: 5 completed ops -> op_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle op sequencer in front of a combinational 32-bit ALU
//
// Purpose: accepts one operation per request handshake, drives the ALU one pass
// per cycle (64-bit add via two carry-chained passes, N-bit shifts via N single-bit
// passes) and returns the result on a response handshake.
//
// Optional feature macro: ALU_OP_SEQUENCER_CNT_EN adds the op_count output.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready/req_op      request channel and opcode
//   req_a, req_b, req_a_hi, req_b_hi  operands (hi words for ADD64, req_b[4:0] = shift count)
//   rsp_valid/rsp_ready             response channel
//   rsp_data, rsp_data_hi, rsp_ovf, rsp_zero  result
//   alu_sel, alu_a, alu_b, alu_carry_in, alu_sign  drive to the ALU
//   alu_out, alu_zero, alu_overflow  results from the ALU
//   op_count                        completed-response counter (macro only)

module alu_op_sequencer #(
    parameter int MAX_SHIFT = 31,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [31:0]      req_a_hi,
    input  logic [31:0]      req_b_hi,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [31:0]      rsp_data_hi,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic [3:0]       alu_sel,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_carry_in,
    output logic             alu_sign,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow
`ifdef ALU_OP_SEQUENCER_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] OP_ADD64 = 3'd4;
    localparam logic [4:0] MAX_SHIFT_W = 5'(MAX_SHIFT);

    logic [2:0]  r_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_a_hi;
    logic [31:0] r_b_hi;
    logic [31:0] r_work;
    logic [4:0]  r_remaining;
    logic        r_lo_zero;
    logic        r_carry;
    logic [31:0] r_rsp_data;
    logic [31:0] r_rsp_data_hi;
    logic        r_rsp_ovf;
    logic        r_rsp_zero;

    logic [4:0]  w_count;
    logic [4:0]  w_count_clamped;
    logic [3:0]  w_shift_sel;

    assign w_count         = r_b[4:0];
    assign w_count_clamped = (w_count > MAX_SHIFT_W) ? MAX_SHIFT_W : w_count;

    always_comb begin
        case (r_op)
            3'd5:    w_shift_sel = 4'd4;
            3'd6:    w_shift_sel = 4'd5;
            3'd7:    w_shift_sel = 4'd7;
            default: w_shift_sel = 4'd0;
        endcase
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_data_hi = r_rsp_data_hi;
    assign rsp_ovf     = r_rsp_ovf;
    assign rsp_zero    = r_rsp_zero;

    // ALU drive is purely a function of state, so an async reset forces it to 0 at once.
    always_comb begin
        alu_sel      = 4'd0;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_carry_in = 1'b0;
        alu_sign     = 1'b0;
        case (r_state)
            S_EXEC: begin
                if (r_op < OP_ADD64) begin
                    // op[0] selects SUB, op[1] selects the unsigned variants
                    alu_sel  = {3'd0, r_op[0]};
                    alu_sign = ~r_op[1];
                    alu_a    = r_a;
                    alu_b    = r_b;
                end
            end
            S_LO: begin
                alu_a = r_a;
                alu_b = r_b;
            end
            S_HI: begin
                alu_a        = r_a_hi;
                alu_b        = r_b_hi;
                alu_carry_in = r_carry;
            end
            S_SHIFT: begin
                alu_sel = w_shift_sel;
                alu_a   = r_work;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= 3'd0;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_a_hi        <= 32'd0;
            r_b_hi        <= 32'd0;
            r_work        <= 32'd0;
            r_remaining   <= 5'd0;
            r_lo_zero     <= 1'b0;
            r_carry       <= 1'b0;
            r_rsp_data    <= 32'd0;
            r_rsp_data_hi <= 32'd0;
            r_rsp_ovf     <= 1'b0;
            r_rsp_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_a_hi  <= req_a_hi;
                        r_b_hi  <= req_b_hi;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op < OP_ADD64) begin
                        r_rsp_data    <= alu_out;
                        r_rsp_data_hi <= 32'd0;
                        r_rsp_ovf     <= alu_overflow;
                        r_rsp_zero    <= alu_zero;
                        r_state       <= S_RESP;
                    end else if (r_op == OP_ADD64) begin
                        r_state <= S_LO;
                    end else if (w_count == 5'd0) begin
                        r_rsp_data    <= r_a;
                        r_rsp_data_hi <= 32'd0;
                        r_rsp_ovf     <= 1'b0;
                        r_rsp_zero    <= (r_a == 32'd0);
                        r_state       <= S_RESP;
                    end else begin
                        r_work      <= r_a;
                        r_remaining <= w_count_clamped;
                        r_state     <= S_SHIFT;
                    end
                end
                S_LO: begin
                    r_rsp_data <= alu_out;
                    r_lo_zero  <= alu_zero;
                    r_carry    <= alu_overflow;
                    r_state    <= S_HI;
                end
                S_HI: begin
                    r_rsp_data_hi <= alu_out;
                    r_rsp_ovf     <= alu_overflow;
                    r_rsp_zero    <= r_lo_zero & alu_zero;
                    r_state       <= S_RESP;
                end
                S_SHIFT: begin
                    r_work      <= alu_out;
                    r_remaining <= r_remaining - 5'd1;
                    if (r_remaining == 5'd1) begin
                        r_rsp_data    <= alu_out;
                        r_rsp_data_hi <= 32'd0;
                        r_rsp_ovf     <= 1'b0;
                        r_rsp_zero    <= alu_zero;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_CNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU

module tb_alu_op_sequencer;

    localparam int MAX_SHIFT = 31;
    localparam int CNT_W     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [31:0] req_a_hi = 32'd0;
    logic [31:0] req_b_hi = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] rsp_data_hi;
    logic        rsp_ovf;
    logic        rsp_zero;
    logic [3:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_carry_in;
    logic        alu_sign;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_overflow;
`ifdef ALU_OP_SEQUENCER_CNT_EN
    logic [CNT_W-1:0] op_count;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer #(.MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_data_hi(rsp_data_hi), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carry_in(alu_carry_in), .alu_sign(alu_sign),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
`ifdef ALU_OP_SEQUENCER_CNT_EN
        , .op_count(op_count)
`endif
    );

    // Behavioural ALU: overflow is signed overflow when Sign=1, carry/borrow otherwise
    logic [32:0] m_c33;
    always_comb begin
        m_c33        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = 32'd0;
        alu_overflow = 1'b0;
        case (alu_sel)
            4'd0: begin
                alu_out      = alu_a + alu_b + {31'd0, alu_carry_in};
                alu_overflow = alu_sign ? ((alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31])) : m_c33[32];
            end
            4'd1: begin
                alu_out      = alu_a - alu_b;
                alu_overflow = alu_sign ? ((alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31])) : (alu_a < alu_b);
            end
            4'd4: alu_out = alu_a << 1;
            4'd5: alu_out = alu_a >> 1;
            4'd7: alu_out = $unsigned($signed(alu_a) >>> 1);
            default: ;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    typedef struct {
        logic [31:0] data;
        logic [31:0] hi;
        logic        ovf;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int hs_cyc = 0;
    int rsp_lat = 0;
    logic [3:0] tr_sel [0:63];
    logic       tr_sign[0:63];
    logic       tr_cin [0:63];

    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] ah, input logic [31:0] bh);
        exp_t e;
        logic [32:0] s33;
        logic [63:0] s64;
        logic [31:0] r;
        int n;
        e.hi  = 32'd0;
        e.ovf = 1'b0;
        e.lat = 2;
        r     = 32'd0;
        s64   = 64'd0;
        case (op)
            3'd0: begin r = a + b; e.ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin r = a - b; e.ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: begin s33 = {1'b0, a} + {1'b0, b}; r = s33[31:0]; e.ovf = s33[32]; end
            3'd3: begin r = a - b; e.ovf = (a < b); end
            3'd4: begin
                s64   = {ah, a} + {bh, b};
                r     = s64[31:0];
                e.hi  = s64[63:32];
                s33   = {1'b0, ah} + {1'b0, bh};
                e.ovf = s33[32];
                e.lat = 4;
            end
            default: begin
                n = int'(b[4:0]);
                if (n > MAX_SHIFT) n = MAX_SHIFT;
                if (op == 3'd5)      r = a << n;
                else if (op == 3'd6) r = a >> n;
                else                 r = $unsigned($signed(a) >>> n);
                e.lat = 2 + n;
            end
        endcase
        e.data = r;
        e.zero = (op == 3'd4) ? (s64 == 64'd0) : (r == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ah, input logic [31:0] bh);
        int k = 0;
        for (int i = 0; i < 64; i++) begin
            tr_sel[i] = 4'd0; tr_sign[i] = 1'b0; tr_cin[i] = 1'b0;
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_a_hi = ah; req_b_hi = bh;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL req_accept_timeout req_ready=%0b required=1", req_ready);
        end
        hs_cyc = cyc;
        sb.push_back(ref_model(op, a, b, ah, bh));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int idx;
        rsp_lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            idx = cyc - hs_cyc;
            if (idx >= 0 && idx < 64) begin
                tr_sel[idx] = alu_sel; tr_sign[idx] = alu_sign; tr_cin[idx] = alu_carry_in;
            end
            if (rsp_valid) begin
                rsp_lat = idx;
                break;
            end
        end
        if (rsp_lat < 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout rsp_valid=%0b required=1", rsp_valid);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_handshake ready/valid=%b required=10", {req_ready, rsp_valid});
        end
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== 66'd0) begin
            bad++; $display("FAIL reset_rsp data=%h hi=%h ovf=%b zero=%b required all 0", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero);
        end
        total++;
        if ({alu_sel, alu_a, alu_b, alu_carry_in, alu_sign} !== 70'd0) begin
            bad++; $display("FAIL reset_alu sel=%h a=%h b=%h cin=%b sign=%b required all 0", alu_sel, alu_a, alu_b, alu_carry_in, alu_sign);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t e;
        issue(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL add_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        total++;
        if ({rsp_data, rsp_ovf, rsp_zero, rsp_data_hi} !== {32'h8000_0000, 1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL add_value data=%h ovf=%b zero=%b hi=%h required 80000000/1/0/0", rsp_data, rsp_ovf, rsp_zero, rsp_data_hi);
        end
        total++;
        if (rsp_lat != 2) begin
            bad++; $display("FAIL add_latency got %0d required 2", rsp_lat);
        end
        finish_rsp();
    endtask

    task automatic test_subu();
        exp_t e;
        issue(3'd3, 32'd5, 32'd5, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL subu_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        total++;
        if ({rsp_data, rsp_zero} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL subu_zero data=%h zero=%b required 0/1", rsp_data, rsp_zero);
        end
        total++;
        if ({tr_sel[1], tr_sign[1]} !== {4'd1, 1'b0}) begin
            bad++; $display("FAIL subu_exec_drive sel=%h sign=%b required 1/0", tr_sel[1], tr_sign[1]);
        end
        finish_rsp();
    endtask

    task automatic test_add64();
        exp_t e;
        issue(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL add64_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        total++;
        if ({rsp_data, rsp_data_hi, rsp_zero} !== {32'd0, 32'd2, 1'b0}) begin
            bad++; $display("FAIL add64_value data=%h hi=%h zero=%b required 0/2/0", rsp_data, rsp_data_hi, rsp_zero);
        end
        total++;
        if (tr_cin[3] !== 1'b1) begin
            bad++; $display("FAIL add64_hi_carry carry_in=%b required 1", tr_cin[3]);
        end
        total++;
        if (rsp_lat != 4) begin
            bad++; $display("FAIL add64_latency got %0d required 4", rsp_lat);
        end
        finish_rsp();
    endtask

    task automatic test_shift();
        exp_t e;
        int n7;
        issue(3'd7, 32'h8000_0010, 32'd4, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        n7 = 0;
        for (int i = 0; i < 64; i++) if (tr_sel[i] == 4'd7) n7++;
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL sra_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        total++;
        if (rsp_data !== 32'hF800_0001) begin
            bad++; $display("FAIL sra_value data=%h required f8000001", rsp_data);
        end
        total++;
        if (n7 != 4 || rsp_lat != 6) begin
            bad++; $display("FAIL sra_passes passes=%0d latency=%0d required 4/6", n7, rsp_lat);
        end
        finish_rsp();

        issue(3'd5, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_zero, rsp_ovf} !== {32'd0, 1'b1, 1'b0} || rsp_lat != 2) begin
            bad++; $display("FAIL sll0 data=%h zero=%b ovf=%b latency=%0d required 0/1/0/2", rsp_data, rsp_zero, rsp_ovf, rsp_lat);
        end
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL sll0_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        finish_rsp();
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0]  op;
        logic [31:0] a, b, ah, bh;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom; ah = $urandom; bh = $urandom;
            if (i == 0) b = 32'd31;
            if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'd1; ah = 32'hFFFF_FFFF; bh = 32'd0; op = 3'd4; end
            issue(op, a, b, ah, bh);
            wait_rsp();
            e = sb.pop_front();
            total++;
            if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero} || rsp_lat != e.lat) begin
                bad++; $display("FAIL random_op%0d op=%0d got %h/%h/%b/%b lat=%0d required %h/%h/%b/%b lat=%0d", i, op,
                                rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, rsp_lat, e.data, e.hi, e.ovf, e.zero, e.lat);
            end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [65:0] snap;
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        wait_rsp();
        snap = {rsp_data, rsp_data_hi, rsp_ovf, rsp_zero};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d out=%h valid=%b ready=%b required %h/1/0", i,
                                {rsp_data, rsp_data_hi, rsp_ovf, rsp_zero}, rsp_valid, req_ready, snap);
            end
        end
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_data_hi, rsp_ovf, rsp_zero} !== {e.data, e.hi, e.ovf, e.zero}) begin
            bad++; $display("FAIL hold_sb got %h/%h/%b/%b required %h/%h/%b/%b", rsp_data, rsp_data_hi, rsp_ovf, rsp_zero, e.data, e.hi, e.ovf, e.zero);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(3'd1, 32'd3, 32'd10, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_ovf, rsp_zero} !== {e.data, e.ovf, e.zero}) begin
            bad++; $display("FAIL b2b_first got %h/%b/%b required %h/%b/%b", rsp_data, rsp_ovf, rsp_zero, e.data, e.ovf, e.zero);
        end
        finish_rsp();
        total++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            bad++; $display("FAIL b2b_gap ready/valid=%b required 10", {req_ready, rsp_valid});
        end
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
        wait_rsp();
        e = sb.pop_front();
        total++;
        if ({rsp_data, rsp_ovf, rsp_zero} !== {e.data, e.ovf, e.zero} || rsp_lat != 2) begin
            bad++; $display("FAIL b2b_second got %h/%b/%b lat=%0d required %h/%b/%b lat=2", rsp_data, rsp_ovf, rsp_zero, rsp_lat, e.data, e.ovf, e.zero);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_shift();
        issue(3'd6, 32'hDEAD_BEEF, 32'd20, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        total++;
        if (alu_sel !== 4'd5) begin
            bad++; $display("FAIL midshift_active sel=%h required 5", alu_sel);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, alu_sel, alu_a, alu_b, alu_carry_in, alu_sign} !== {1'b1, 1'b0, 70'd0}) begin
            bad++; $display("FAIL midshift_reset ready=%b valid=%b sel=%h a=%h b=%h required 1/0/0/0/0", req_ready, rsp_valid, alu_sel, alu_a, alu_b);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef ALU_OP_SEQUENCER_CNT_EN
    task automatic test_count();
        logic [CNT_W-1:0] want;
        exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(3'd2, 32'(i), 32'd1, 32'd0, 32'd0);
            wait_rsp();
            e = sb.pop_front();
            finish_rsp();
            want = CNT_W'(i + 1);
            total++;
            if (op_count !== want || e.data !== 32'(i + 1)) begin
                bad++; $display("FAIL op_count_%0d got %0d required %0d", i, op_count, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_subu();
        test_add64();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        test_add();
`ifdef ALU_OP_SEQUENCER_CNT_EN
        test_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
